// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data access controller.
// Issues one req/ack transaction per load/store, stalls the pipeline while it
// is outstanding, and returns a lane-aligned, extended load result.
//
// Handshake: mem_req rises on the edge leaving IDLE. It stays high, with
// mem_we/mem_addr/mem_wdata/mem_wstrb frozen, until the edge that samples
// mem_ack=1 or the edge that ends the TIMEOUT-th WAIT cycle. mem_ack is a
// one-cycle pulse. It is only honoured in WAIT.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignedM,
  input  logic        FlushM,
  input  logic [31:0] ALU_Out_M,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] Data_Mem_Out_M,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [CW-1:0] r_cnt;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_data;
  logic        r_buserr;

  // Latched copies that govern the formatting of the returned load data.
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;

  logic        w_access;
  logic        w_aligned;
  logic        w_timeout;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic        w_stall;
  logic        w_misalign;

  assign w_access  = (MemReadM | MemWriteM) & ~FlushM;
  assign w_aligned = (MemSizeM == 2'b00) |
                     ((MemSizeM == 2'b01) & ~ALU_Out_M[0]) |
                     (MemSizeM[1] & (ALU_Out_M[1:0] == 2'b00));
  // Last WAIT cycle before the abort: the counter is zero in the first one.
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  // Store data replicated across lanes and the matching byte strobes.
  always_comb begin
    w_wdata = WriteDataM;
    w_wstrb = 4'b1111;
    case (MemSizeM)
      2'b00: begin
        w_wdata = {4{WriteDataM[7:0]}};
        w_wstrb = 4'b0001 << ALU_Out_M[1:0];
      end
      2'b01: begin
        w_wdata = {2{WriteDataM[15:0]}};
        w_wstrb = 4'b0011 << ALU_Out_M[1:0];
      end
      default: begin
        w_wdata = WriteDataM;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  // Little-endian lane select and sign/zero extension of the read data.
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_lane)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state plus the combinational stall and misalignment flags.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_misalign  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (w_aligned) begin
            w_stall     = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_misalign  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (mem_ack || w_timeout) w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, timeout counter and registered result/bus error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_wstrb  <= 4'd0;
      r_data   <= 32'd0;
      r_buserr <= 1'b0;
      r_cnt    <= '0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_lane   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_data   <= 32'd0;
          r_buserr <= 1'b0;
          r_cnt    <= '0;
          if (w_access && w_aligned) begin
            r_req    <= 1'b1;
            r_we     <= MemWriteM;
            r_addr   <= {ALU_Out_M[31:2], 2'b00};
            r_wdata  <= MemWriteM ? w_wdata : 32'd0;
            r_wstrb  <= MemWriteM ? w_wstrb : 4'd0;
            r_size   <= MemSizeM;
            r_signed <= MemSignedM;
            r_lane   <= ALU_Out_M[1:0];
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (mem_ack) begin
            r_req  <= 1'b0;
            r_data <= r_we ? 32'd0 : w_load;
          end else if (w_timeout) begin
            r_req    <= 1'b0;
            r_data   <= 32'd0;
            r_buserr <= 1'b1;
          end
        end
        S_DONE: begin
          r_data   <= 32'd0;
          r_buserr <= 1'b0;
          r_cnt    <= '0;
        end
        default: begin
          r_req <= 1'b0;
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign mem_req        = r_req;
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  assign mem_wstrb      = r_wstrb;
  assign Data_Mem_Out_M = r_data;
  assign BusErrM        = r_buserr;
  assign StallM         = w_stall;
  assign MisalignM      = w_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed, table-driven bench for mem_access_unit
// (built with TIMEOUT=4), plus hand sequences for stray ack and reset.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        MemReadM, MemWriteM, MemSignedM, FlushM;
  logic [1:0]  MemSizeM;
  logic [31:0] ALU_Out_M, WriteDataM;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] Data_Mem_Out_M;
  logic        StallM, MisalignM, BusErrM;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
    .MemSignedM(MemSignedM), .FlushM(FlushM),
    .ALU_Out_M(ALU_Out_M), .WriteDataM(WriteDataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .Data_Mem_Out_M(Data_Mem_Out_M), .StallM(StallM),
    .MisalignM(MisalignM), .BusErrM(BusErrM)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, need completion");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // kind: 0 = aligned access, 1 = misaligned, 2 = no access (flushed)
  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic        flush;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ack_dly;   // WAIT cycle carrying the ack, 0 = never
    int          kind;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_dout;
    logic        exp_bus;
    int          exp_stalls;
  } vec_t;

  vec_t vecs[17];

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; MemSizeM = 2'b00; MemSignedM = 1'b0;
    FlushM = 1'b0; ALU_Out_M = 32'd0; WriteDataM = 32'd0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int stalls, reqs, waits;
    bit done;
    @(negedge clk);
    MemReadM = v.rd; MemWriteM = v.wr; MemSizeM = v.size; MemSignedM = v.sgn;
    FlushM = v.flush; ALU_Out_M = v.addr; WriteDataM = v.wd;
    #1;
    if (v.kind != 0) begin
      chk($sformatf("v%0d misalign", idx), {31'd0, MisalignM}, (v.kind == 1) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d stall", idx), {31'd0, StallM}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d no_req", idx), {31'd0, mem_req}, 32'd0);
      clear_inputs();
      return;
    end
    chk($sformatf("v%0d stall_c0", idx), {31'd0, StallM}, 32'd1);
    chk($sformatf("v%0d misalign_c0", idx), {31'd0, MisalignM}, 32'd0);
    exp_q.push_back(v.exp_dout);
    @(negedge clk);
    // Scramble live inputs: the latched copies must govern the transaction.
    MemReadM = 1'b0; MemWriteM = 1'b0; FlushM = 1'b1; MemSizeM = 2'b00;
    MemSignedM = ~v.sgn; ALU_Out_M = 32'hFFFF_FFFF; WriteDataM = ~v.wd;
    chk($sformatf("v%0d req", idx), {31'd0, mem_req}, 32'd1);
    chk($sformatf("v%0d we", idx), {31'd0, mem_we}, {31'd0, v.exp_we});
    chk($sformatf("v%0d addr", idx), mem_addr, v.exp_addr);
    chk($sformatf("v%0d wstrb", idx), {28'd0, mem_wstrb}, {28'd0, v.exp_wstrb});
    if (v.exp_we) chk($sformatf("v%0d wdata", idx), mem_wdata, v.exp_wdata);
    stalls = 1; reqs = 0; waits = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (StallM) begin
        stalls++; waits++;
        if (mem_req) reqs++;
        if (waits == v.ack_dly) begin
          mem_ack = 1'b1; mem_rdata = v.rdata;
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = $urandom;
      end else begin
        done = 1'b1;
      end
    end
    chk($sformatf("v%0d reached_done", idx), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d stall_cycles", idx), stalls, v.exp_stalls);
    chk($sformatf("v%0d req_cycles", idx), reqs, (v.ack_dly == 0) ? TO : v.ack_dly);
    chk($sformatf("v%0d req_done", idx), {31'd0, mem_req}, 32'd0);
    chk($sformatf("v%0d dout", idx), Data_Mem_Out_M, exp_q.pop_front());
    chk($sformatf("v%0d buserr", idx), {31'd0, BusErrM}, {31'd0, v.exp_bus});
    @(negedge clk);
    chk($sformatf("v%0d idle_dout", idx), Data_Mem_Out_M, 32'd0);
    chk($sformatf("v%0d idle_buserr", idx), {31'd0, BusErrM}, 32'd0);
    clear_inputs();
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{1,0,2'b10,0,0,32'h100,32'h0,32'hDEADBEEF,1,0,0,32'h100,32'h0,4'b0000,32'hDEADBEEF,0,2};
    vecs[1]  = '{1,0,2'b00,1,0,32'h103,32'h0,32'h80FF7F01,2,0,0,32'h100,32'h0,4'b0000,32'hFFFFFF80,0,3};
    vecs[2]  = '{1,0,2'b00,0,0,32'h103,32'h0,32'h80FF7F01,1,0,0,32'h100,32'h0,4'b0000,32'h00000080,0,2};
    vecs[3]  = '{1,0,2'b01,1,0,32'h102,32'h0,32'h80FF7F01,1,0,0,32'h100,32'h0,4'b0000,32'hFFFF80FF,0,2};
    vecs[4]  = '{1,0,2'b01,1,0,32'h100,32'h0,32'h80FF7F01,3,0,0,32'h100,32'h0,4'b0000,32'h00007F01,0,4};
    vecs[5]  = '{1,0,2'b00,1,0,32'h101,32'h0,32'h80FF7F01,1,0,0,32'h100,32'h0,4'b0000,32'h0000007F,0,2};
    vecs[6]  = '{1,0,2'b00,1,0,32'h102,32'h0,32'h80FF7F01,1,0,0,32'h100,32'h0,4'b0000,32'hFFFFFFFF,0,2};
    vecs[7]  = '{0,1,2'b00,0,0,32'h201,32'h000000AB,32'h12345678,1,0,1,32'h200,32'hABABABAB,4'b0010,32'h0,0,2};
    vecs[8]  = '{0,1,2'b01,0,0,32'h302,32'h1234CDEF,32'h12345678,2,0,1,32'h300,32'hCDEFCDEF,4'b1100,32'h0,0,3};
    vecs[9]  = '{0,1,2'b10,0,0,32'h404,32'h11223344,32'hFFFFFFFF,4,0,1,32'h404,32'h11223344,4'b1111,32'h0,0,5};
    vecs[10] = '{1,1,2'b10,0,0,32'h500,32'hCAFEF00D,32'h55555555,1,0,1,32'h500,32'hCAFEF00D,4'b1111,32'h0,0,2};
    vecs[11] = '{1,0,2'b11,1,0,32'h600,32'h0,32'hA5A55A5A,3,0,0,32'h600,32'h0,4'b0000,32'hA5A55A5A,0,4};
    vecs[12] = '{1,0,2'b10,0,0,32'h102,32'h0,32'h0,1,1,0,32'h0,32'h0,4'b0000,32'h0,0,0};
    vecs[13] = '{0,1,2'b01,0,0,32'h301,32'h1234,32'h0,1,1,0,32'h0,32'h0,4'b0000,32'h0,0,0};
    vecs[14] = '{1,0,2'b11,0,0,32'h602,32'h0,32'h0,1,1,0,32'h0,32'h0,4'b0000,32'h0,0,0};
    vecs[15] = '{1,0,2'b10,0,1,32'h101,32'h0,32'h0,1,2,0,32'h0,32'h0,4'b0000,32'h0,0,0};
    vecs[16] = '{1,0,2'b10,0,0,32'h700,32'h0,32'h0,0,0,0,32'h700,32'h0,4'b0000,32'h0,1,5};

    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    clear_inputs();
    repeat (3) @(negedge clk);
    // Reset state.
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst dout", Data_Mem_Out_M, 32'd0);
    chk("rst buserr", {31'd0, BusErrM}, 32'd0);
    chk("rst stall", {31'd0, StallM}, 32'd0);
    chk("rst misalign", {31'd0, MisalignM}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Stray ack in IDLE right after the timeout access.
    mem_ack = 1'b1; mem_rdata = 32'h13572468;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack req", {31'd0, mem_req}, 32'd0);
    chk("stray_ack stall", {31'd0, StallM}, 32'd0);
    chk("stray_ack dout", Data_Mem_Out_M, 32'd0);
    chk("stray_ack buserr", {31'd0, BusErrM}, 32'd0);

    // Reset during the second WAIT cycle.
    @(negedge clk);
    MemReadM = 1'b1; MemSizeM = 2'b10; ALU_Out_M = 32'h800;
    @(negedge clk);
    clear_inputs();
    chk("rst_mid req_wait1", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    chk("rst_mid stall_wait2", {31'd0, StallM}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid mem_addr", mem_addr, 32'd0);
    chk("rst_mid mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mid stall", {31'd0, StallM}, 32'd0);
    chk("rst_mid dout", Data_Mem_Out_M, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(100, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data access controller for the 5-stage pipeline. It sits between the EX/MEM and MEM/WB pipeline registers. It takes the MEM-stage control bits, the ALU result (the address) and the store data, and runs a req/ack transaction on the external data-memory port. It stalls the pipeline while the access is outstanding, then presents a lane-aligned, sign/zero-extended load result as Data_Mem_Out_M for the MEM/WB register to capture.

## Interface
- TIMEOUT, 16: maximum WAIT cycles without mem_ack before the access is aborted (≥2)
- clk  input  1  pipeline clock, all state on posedge
- rst_n  input  1  asynchronous, active-low reset
- MemReadM  input  1  load in MEM stage
- MemWriteM  input  1  store in MEM stage; has priority if both are set
- MemSizeM  input  2  00 byte, 01 half, 10 word, 11 treated as word
- MemSignedM  input  1  1 = sign-extend a byte/half load, 0 = zero-extend
- FlushM  input  1  kill the MEM-stage instruction (only honoured in IDLE)
- ALU_Out_M  input  32  byte address
- WriteDataM  input  32  store data, in the low bits
- mem_req  output  1  transaction request, registered
- mem_we  output  1  1 = write, registered
- mem_addr  output  32  word address {ALU_Out_M[31:2],2'b00}, registered
- mem_wdata  output  32  store data replicated across lanes, registered
- mem_wstrb  output  4  byte-lane write strobes, registered (0 on reads)
- mem_rdata  input  32  read data, valid with mem_ack
- mem_ack  input  1  one-cycle completion pulse
- Data_Mem_Out_M  output  32  formatted load data, registered
- StallM  output  1  holds IF..MEM stages, combinational
- MisalignM  output  1  misaligned access flagged this cycle, combinational
- BusErrM  output  1  timeout abort, asserted in the DONE cycle, registered

## Operation
- access = (MemReadM | MemWriteM) & ~FlushM.
- aligned: byte always; half requires addr[0]=0; word requires addr[1:0]=0.
- FSM states: IDLE, WAIT, DONE.
- **IDLE:**
  - If access & aligned: latch request outputs, set mem_req=1, go to WAIT, StallM=1.
  - If access & ~aligned: MisalignM=1, StallM=0, no request, stay in IDLE.
  - Otherwise StallM=0 and Data_Mem_Out_M=0.
- **WAIT:**
  - StallM=1.
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb are held stable.
  - Timeout counter increments each cycle.
  - On mem_ack: capture the formatted rdata into Data_Mem_Out_M (0 for stores), clear mem_req, go to DONE.
  - If the counter reaches TIMEOUT without an ack: clear mem_req, set Data_Mem_Out_M=0 and BusErrM=1, go to DONE.
- **DONE:**
  - StallM=0, so the pipeline advances and MEM/WB captures Data_Mem_Out_M at this edge.
  - Next state is IDLE; BusErrM clears; the counter resets.
- Load formatting is little-endian.
  - Byte: lane addr[1:0], bits [8*lane+7 : 8*lane].
  - Half: lane addr[1] selects [15:0] or [31:16].
  - The selected field is extended to 32 bits per MemSignedM.
- Store formatting:
  - byte: wdata={4{WD[7:0]}}, wstrb=0001<<addr[1:0]
  - half: wdata={2{WD[15:0]}}, wstrb=0011<<addr[1:0]
  - word: wdata=WD, wstrb=1111
- Inputs may change after the IDLE→WAIT edge; the latched copies govern the transaction, including the load formatting.
- A mem_ack while in IDLE or DONE is ignored.
- FlushM asserted during WAIT/DONE is ignored: the transaction completes.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, Data_Mem_Out_M=0, BusErrM=0, counter=0. The combinational StallM and MisalignM follow from this.
- rst_n low during WAIT: mem_req drops immediately (asynchronously) and the transaction is abandoned.
- Best case: request seen in cycle 0, ack in cycle 1, DONE in cycle 2, giving 2 stall cycles; data is valid during cycle 2.
- In general, stall cycles = 1 + (number of WAIT cycles up to and including the ack cycle).
- Timeout: mem_req is high for exactly TIMEOUT cycles; DONE follows on the next cycle.
- Back-to-back accesses: the next instruction is evaluated in IDLE the cycle after DONE. There are no idle req gaps beyond DONE+IDLE.

## Test plan
- **Word load:** load word at 0x100, ack one cycle after req with rdata=0xDEADBEEF → mem_addr=0x100, mem_we=0, wstrb=0; StallM high for 2 cycles; Data_Mem_Out_M=0xDEADBEEF in DONE.
- **Signed byte load:** signed byte load at 0x103, rdata=0x80FF7F01 → 0xFFFFFF80; the same access unsigned → 0x00000080. Signed half load at 0x102 → 0xFFFF80FF.
- **Byte store:** byte store of WD=0x000000AB at 0x201 → mem_wdata=0xABABABAB, mem_wstrb=0010, mem_addr=0x200, mem_we=1; Data_Mem_Out_M=0.
- **Misaligned:** word load at 0x102 → MisalignM=1, StallM=0, mem_req never rises. Half store at 0x301 → same.
- **Timeout and late ack:** TIMEOUT=4, never ack → mem_req high 4 cycles, then BusErrM=1 and Data_Mem_Out_M=0 for one cycle, then IDLE. A stray ack on the next cycle is ignored.
- **Reset mid-transaction:** assert rst_n=0 in the 2nd WAIT cycle → mem_req=0 at once and all outputs at their reset values. After release, a new load completes normally.
